// File: rtl/conv_window_seq.sv
// Pixel-window sequencer: walks a raster stream, drives the window-bank load enable and
// flags complete K x K windows to the MAC array. Define CONV_WIN_STRIDE2_EN for stride-2 windows.
module conv_window_seq #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 3,
    parameter int CW    = $clog2(IMG_W),
    parameter int RW    = $clog2(IMG_H)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          reg_en,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [CW-1:0] win_x,
    output logic [RW-1:0] win_y,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] KM1_C    = CW'(K - 1);
    localparam logic [RW-1:0] KM1_R    = RW'(K - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          win_valid_q, win_valid_d;
    logic [CW-1:0] win_x_q, win_x_d;
    logic [RW-1:0] win_y_q, win_y_d;

    logic          at_window;
    logic          new_win;
    logic [CW-1:0] wx;
    logic [RW-1:0] wy;

    assign wx = col_q - KM1_C;
    assign wy = row_q - KM1_R;

    // A pending, unconsumed window freezes the bank until the MAC array takes it.
    assign in_ready = (state_q == RUN) && !(win_valid_q && !win_ready);
    assign reg_en   = in_valid & in_ready;

`ifdef CONV_WIN_STRIDE2_EN
    assign at_window = (int'(col_q) >= K - 1) && (int'(row_q) >= K - 1) && !wx[0] && !wy[0];
`else
    assign at_window = (int'(col_q) >= K - 1) && (int'(row_q) >= K - 1);
`endif

    assign new_win = reg_en & at_window;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        win_valid_d = win_valid_q & !win_ready;
        win_x_d     = win_x_q;
        win_y_d     = win_y_q;

        if (new_win) begin
            win_valid_d = 1'b1;
            win_x_d     = wx;
            win_y_d     = wy;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            RUN: begin
                if (reg_en) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!win_valid_q || win_ready) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            win_x_q     <= '0;
            win_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            win_x_q     <= win_x_d;
            win_y_q     <= win_y_d;
        end
    end

    assign win_valid = win_valid_q;
    assign win_x     = win_x_q;
    assign win_y     = win_y_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule
